// File: rtl/instr_fetch_responder_if.sv
// Bundle of signals between the PC stage, instruction memory and decode
// that the fetch responder sits between.
interface instr_fetch_responder_if #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned INSTR_W = 32
);
    logic               flush;
    logic               req_valid;
    logic [ADDR_W-1:0]  req_addr;
    logic               req_ready;
    logic               mem_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               rsp_valid;
    logic [ADDR_W-1:0]  rsp_addr;
    logic [INSTR_W-1:0] rsp_instr;
    logic               rsp_ready;
    logic               busy;
    logic               seq_err;

    // Responder side
    modport slave (
        input  flush, req_valid, req_addr, mem_rdata, rsp_ready,
        output req_ready, mem_en, mem_addr, rsp_valid, rsp_addr, rsp_instr,
               busy, seq_err
    );

    // Environment side: PC stage, memory and decode together
    modport master (
        output flush, req_valid, req_addr, mem_rdata, rsp_ready,
        input  req_ready, mem_en, mem_addr, rsp_valid, rsp_addr, rsp_instr,
               busy, seq_err
    );
endinterface

// File: rtl/instr_fetch_responder.sv
// Fetch responder: turns PC requests into memory reads and queues the returned
// instructions, with their addresses, in order toward decode.
module instr_fetch_responder #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DEPTH   = 4
) (
    input logic                   clk,
    input logic                   rst,
    instr_fetch_responder_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0]  r_addr_q  [DEPTH];
    logic [INSTR_W-1:0] r_instr_q [DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_addr;
    logic               r_seq_armed;
    logic [ADDR_W-1:0]  r_last_addr;
    logic               r_seq_err;

    logic [OCC_W-1:0]   w_occ;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_rsp_valid;
    logic [ADDR_W-1:0]  w_next_addr;

    // Reserve a queue slot for the read in flight so the fill can never overflow
    assign w_occ       = OCC_W'(r_count) + OCC_W'(r_inflight);
    assign w_req_ready = !bus.flush && (w_occ < OCC_W'(DEPTH));
    assign w_accept    = rst && bus.req_valid && w_req_ready;
    assign w_push      = r_inflight;
    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid && bus.rsp_ready;
    assign w_next_addr = r_last_addr + ADDR_W'(1);

    assign bus.req_ready = w_req_ready;
    assign bus.mem_en    = w_accept;
    assign bus.mem_addr  = bus.req_addr;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_addr  = r_addr_q[r_rptr];
    assign bus.rsp_instr = r_instr_q[r_rptr];
    assign bus.busy      = w_rsp_valid || r_inflight;
    assign bus.seq_err   = r_seq_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_addr_q[i]  <= '0;
                r_instr_q[i] <= '0;
            end
            r_count         <= '0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_seq_armed     <= 1'b0;
            r_last_addr     <= '0;
            r_seq_err       <= 1'b0;
        end else begin
            // Request acceptance and address-sequence tracking
            if (w_accept) begin
                r_inflight      <= 1'b1;
                r_inflight_addr <= bus.req_addr;
                r_last_addr     <= bus.req_addr;
                r_seq_armed     <= 1'b1;
                if (r_seq_armed && (bus.req_addr != w_next_addr)) begin
                    r_seq_err <= 1'b1;
                end
            end else begin
                r_inflight <= 1'b0;
            end

            // Flush drops both the queue and any read returning next cycle
            if (bus.flush) begin
                r_count     <= '0;
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_inflight  <= 1'b0;
                r_seq_armed <= 1'b0;
            end else begin
                if (w_push) begin
                    r_addr_q[r_wptr]  <= r_inflight_addr;
                    r_instr_q[r_wptr] <= bus.mem_rdata;
                    r_wptr            <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && (r_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: a registered memory model returns
// 0xA000_0000|addr and every check compares against hand-derived values.
module tb_instr_fetch_responder;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DEPTH   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    instr_fetch_responder_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus();

    instr_fetch_responder #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] exp_instr(input logic [ADDR_W-1:0] a);
        return 32'hA000_0000 | INSTR_W'(a);
    endfunction

    // Synchronous-read memory; garbage while reset is held
    always @(posedge clk) begin
        if (!rst)             bus.mem_rdata <= $urandom;
        else if (bus.mem_en)  bus.mem_rdata <= exp_instr(bus.mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        bus.flush     = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("flush_req_ready", 64'(bus.req_ready), 64'(0));
        next_cycle();
        bus.flush = 1'b0;
    endtask

    logic [ADDR_W-1:0] t2_addr [6];
    int a;
    int exp_a;
    int n_acc;

    initial begin
        t2_addr = '{6'd60, 6'd61, 6'd62, 6'd63, 6'd0, 6'd1};
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;

        // Reset held with random inputs; req_valid forced high to probe mem_en
        for (int i = 0; i < 4; i++) begin
            bus.flush     = 1'($urandom);
            bus.req_valid = 1'b1;
            bus.req_addr  = ADDR_W'($urandom);
            bus.rsp_ready = 1'($urandom);
            @(negedge clk);
            check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            check("rst_busy",      64'(bus.busy),      64'(0));
            check("rst_seq_err",   64'(bus.seq_err),   64'(0));
            check("rst_mem_en",    64'(bus.mem_en),    64'(0));
            check("rst_rsp_addr",  64'(bus.rsp_addr),  64'(0));
            check("rst_rsp_instr", 64'(bus.rsp_instr), 64'(0));
            next_cycle();
        end
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("post_rst_busy",      64'(bus.busy),      64'(0));
        check("post_rst_seq_err",   64'(bus.seq_err),   64'(0));
        next_cycle();

        // Streaming across the 63 -> 0 wrap, one response per cycle
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = (i < 6);
            if (i < 6) bus.req_addr = t2_addr[i];
            @(negedge clk);
            if (i < 6) check("t2_mem_en", 64'(bus.mem_en), 64'(1));
            if (i < 2) begin
                check("t2_early_valid", 64'(bus.rsp_valid), 64'(0));
            end else begin
                check("t2_rsp_valid", 64'(bus.rsp_valid), 64'(1));
                check("t2_rsp_addr",  64'(bus.rsp_addr),  64'(t2_addr[i-2]));
                check("t2_rsp_instr", 64'(bus.rsp_instr), 64'(exp_instr(t2_addr[i-2])));
            end
            next_cycle();
        end
        @(negedge clk);
        check("t2_seq_err", 64'(bus.seq_err), 64'(0));
        check("t2_busy",    64'(bus.busy),    64'(0));
        next_cycle();

        // Backpressure: queue plus in-flight slot fills at exactly 4 accepts
        do_flush();
        bus.rsp_ready = 1'b0;
        a = 0;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = ADDR_W'(a);
            @(negedge clk);
            if (bus.req_ready) begin
                n_acc++;
                a++;
            end
            if (i >= 4) begin
                check("t3_head_addr",  64'(bus.rsp_addr),  64'(0));
                check("t3_head_instr", 64'(bus.rsp_instr), 64'(32'hA000_0000));
            end
            next_cycle();
        end
        @(negedge clk);
        check("t3_accepts",   64'(n_acc),         64'(4));
        check("t3_req_ready", 64'(bus.req_ready), 64'(0));
        check("t3_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        next_cycle();

        bus.rsp_ready = 1'b1;
        exp_a = 0;
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = ADDR_W'(a);
            @(negedge clk);
            check("t3_drain_valid", 64'(bus.rsp_valid), 64'(1));
            check("t3_drain_addr",  64'(bus.rsp_addr),  64'(exp_a));
            check("t3_drain_instr", 64'(bus.rsp_instr), 64'(exp_instr(ADDR_W'(exp_a))));
            exp_a++;
            if (bus.req_ready) a++;
            next_cycle();
        end
        check("t3_resume_count", 64'(a), 64'(11));
        check("t3_seq_err", 64'(bus.seq_err), 64'(0));
        bus.req_valid = 1'b0;
        do_flush();

        // Flush with a read in flight
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd5;
        @(negedge clk);
        check("t4_mem_en", 64'(bus.mem_en), 64'(1));
        next_cycle();
        do_flush();
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd20;
        @(negedge clk);
        check("t4_rsp_valid_after_flush", 64'(bus.rsp_valid), 64'(0));
        check("t4_busy_after_flush",      64'(bus.busy),      64'(0));
        next_cycle();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("t4_rsp_valid_lat1", 64'(bus.rsp_valid), 64'(0));
        next_cycle();
        @(negedge clk);
        check("t4_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        check("t4_rsp_addr",  64'(bus.rsp_addr),  64'(20));
        check("t4_rsp_instr", 64'(bus.rsp_instr), 64'(32'hA000_0014));
        check("t4_seq_err",   64'(bus.seq_err),   64'(0));
        next_cycle();
        @(negedge clk);
        check("t4_busy_end", 64'(bus.busy), 64'(0));
        next_cycle();

        // Sequence error is sticky across flush and legal traffic
        do_flush();
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd3;
        next_cycle();
        bus.req_addr  = 6'd7;
        @(negedge clk);
        check("t5_seq_err_before", 64'(bus.seq_err), 64'(0));
        next_cycle();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("t5_seq_err_set", 64'(bus.seq_err), 64'(1));
        next_cycle();
        do_flush();
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd10;
        next_cycle();
        bus.req_addr  = 6'd11;
        next_cycle();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();
        @(negedge clk);
        check("t5_seq_err_sticky", 64'(bus.seq_err), 64'(1));
        next_cycle();

        // Asynchronous reset with 3 queued entries and one read in flight
        do_flush();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = ADDR_W'(30 + k);
            @(negedge clk);
            check("t6_fill_ready", 64'(bus.req_ready), 64'(1));
            next_cycle();
        end
        bus.req_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("t6_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("t6_rst_busy",      64'(bus.busy),      64'(0));
        check("t6_rst_seq_err",   64'(bus.seq_err),   64'(0));
        check("t6_rst_rsp_addr",  64'(bus.rsp_addr),  64'(0));
        check("t6_rst_rsp_instr", 64'(bus.rsp_instr), 64'(0));
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6_stale_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("t6_stale_busy",      64'(bus.busy),      64'(0));
        check("t6_req_ready",       64'(bus.req_ready), 64'(1));
        next_cycle();
        @(negedge clk);
        check("t6_stale_rsp_valid2", 64'(bus.rsp_valid), 64'(0));
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Consumer end of the program-counter interface.
- Accepts instruction-address requests from the PC stage and issues reads to a synchronous-read instruction memory.
- Buffers returned instructions, paired with their addresses, in an in-order output queue with valid/ready backpressure toward decode.
- Flags a sticky error when accepted addresses do not follow the PC's +1 (mod 2^ADDR_W) sequence.

Parameters:
ADDR_W, 6, width of instruction address; PC counts 0..2^ADDR_W-1 and wraps.
INSTR_W, 32, instruction word width.
DEPTH, 4, output queue entries; power of two, >= 2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
flush  input  1  synchronous discard of queued and in-flight fetches.
req_valid  input  1  PC address valid.
req_addr  input  ADDR_W  PC address.
req_ready  output  1  responder can accept a request this cycle.
mem_en  output  1  memory read strobe.
mem_addr  output  ADDR_W  memory read address.
mem_rdata  input  INSTR_W  memory data; valid the cycle after mem_en.
rsp_valid  output  1  queue head valid.
rsp_addr  output  ADDR_W  address of head instruction.
rsp_instr  output  INSTR_W  head instruction.
rsp_ready  input  1  decode consumes head.
busy  output  1  queue non-empty or read in flight.
seq_err  output  1  sticky address-sequence error.

Behaviour:
Clock and reset:
- Reset: clock clk; reset rst, asynchronous, active-low.
- Reset state: queue count = 0, read/write pointers = 0, inflight = 0, inflight_addr = 0, seq_armed = 0, last_addr = 0.
- Outputs during and after reset: rsp_valid = 0, rsp_addr = 0, rsp_instr = 0, busy = 0, seq_err = 0, mem_en = 0.

Request side:
- req_ready = !flush && (count + inflight < DEPTH).
- req_ready depends on registered state and flush only; there is no combinational path from rsp_ready.
- Accept = req_valid && req_ready.
- mem_en = accept; mem_addr = req_addr, combinational pass-through.
- On accept, at the clock edge: inflight <= 1, inflight_addr <= req_addr.
- With no accept: inflight <= 0.

Fill:
- When inflight = 1, mem_rdata is valid this cycle.
- At the edge, push {inflight_addr, mem_rdata} into the queue at the write pointer.
- Latency: accept in cycle n -> entry visible with rsp_valid = 1 in cycle n+2.

Response side:
- rsp_valid = (count != 0).
- rsp_addr / rsp_instr come from the head entry storage.
- Pop = rsp_valid && rsp_ready; the head advances at the edge.
- Head fields hold stable while rsp_valid && !rsp_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Overflow is impossible by the req_ready rule. An implementation assertion must fire if a push occurs at count == DEPTH.
- Pointers wrap modulo DEPTH.
- Throughput: one response per cycle sustained when rsp_ready = 1 and DEPTH >= 3.

Flush:
- Registered effect at the edge: count <= 0, pointers <= 0, inflight <= 0, seq_armed <= 0.
- mem_rdata returning the cycle after a flush is discarded.
- req_ready = 0 in the flush cycle; rsp_valid = 0 the cycle after.
- A pop in the flush cycle is still legal; the entry is considered consumed.

Sequence check:
- On accept with seq_armed = 1 and req_addr != last_addr + 1 (ADDR_W-bit wrap, so 2^ADDR_W-1 -> 0 is legal): seq_err <= 1.
- On every accept: last_addr <= req_addr, seq_armed <= 1.
- seq_err is sticky and cleared only by rst.
- The first accept after reset or flush is not checked.

Other outputs:
- busy = (count != 0) || inflight.

Reset mid-operation:
- Asserting rst at any point immediately returns all state to reset values.
- In-flight memory data is ignored.

Test Plan:
1. Reset: hold rst low with random inputs -> rsp_valid = 0, req_ready = 0 is not required but state = 0; after release req_ready = 1, busy = 0, seq_err = 0.
2. Stream addresses 60,61,62,63,0,1 with rsp_ready = 1; memory returns 0xA000_0000|addr -> first rsp_valid 2 cycles after first accept; one response per cycle in order with matching addr/instr; wrap 63->0 leaves seq_err = 0.
3. Backpressure: rsp_ready = 0, req_valid = 1 on addresses 0.. -> exactly 4 accepts, then req_ready = 0; rsp_addr = 0 and rsp_instr are stable; raise rsp_ready -> drains 0,1,2,3 in order, then accepts resume at 4.
4. Flush with in-flight read: accept addr 5, flush next cycle -> no response for addr 5; rsp_valid = 0; busy = 0 after one cycle; the next accept, addr 20, gives seq_err = 0 and a response for 20.
5. Sequence error: accept 3 then 7 -> seq_err = 1 at the edge after the second accept; it remains 1 through a later flush and a legal stream; only rst clears it.
6. Async reset mid-stream: queue holds 3 entries with one in flight; pulse rst low between clock edges -> outputs zero immediately; after release, stale mem_rdata produces no response.
